// File: rtl/mem_access_pkg.sv
// Shared defines for the memory-access stage: bus widths, reset/write constants,
// mem_op and FSM encodings, plus small op-decode helpers.
package mem_access_pkg;

  localparam int          RegBus       = 32;
  localparam int          RegAddrBus   = 5;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LW   = 3'd1,
    OP_LB   = 3'd2,
    OP_LBU  = 3'd3,
    OP_SW   = 3'd4,
    OP_SB   = 3'd5
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Encodings 6-7 fall outside LW..SB and decode as NONE.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op >= 3'(OP_LW)) && (op <= 3'(OP_SB));
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  // Big-endian lane numbering: lane 0 is the most significant byte.
  function automatic logic [3:0] lane_sel(input logic [1:0] lane);
    return 4'b1000 >> lane;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load formatter: picks the addressed big-endian byte lane and
// sign- or zero-extends it; LW passes the full word through.
module load_align
  import mem_access_pkg::*;
(
  input  mem_op_e             op,
  input  logic [1:0]          lane,
  input  logic [RegBus-1:0]   rdata,
  output logic [RegBus-1:0]   data
);

  logic [7:0] sel_byte;

  always_comb begin
    case (lane)
      2'd0:    sel_byte = rdata[31:24];
      2'd1:    sel_byte = rdata[23:16];
      2'd2:    sel_byte = rdata[15:8];
      default: sel_byte = rdata[7:0];
    endcase
  end

  always_comb begin
    case (op)
      OP_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  data = {24'h000000, sel_byte};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: IDLE/BUSY/DONE bus master with watchdog timeout.
// Optional macro MEM_ALIGN_CHECK_EN rejects misaligned LW/SW without a bus cycle.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegBus-1:0]     wdata,
  input  logic [RegAddrBus-1:0] waddr,
  input  logic                  wr_en,
  input  logic [2:0]            mem_op,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_sdata,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [31:0]           bus_addr,
  output logic [31:0]           bus_wdata,
  output logic [3:0]            bus_sel,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack,
  output logic [RegBus-1:0]     wb_wdata,
  output logic [RegAddrBus-1:0] wb_waddr,
  output logic                  wb_wr_en,
  output logic                  stall_req,
  output logic                  bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e          state;
  mem_op_e         op_in, op_q;
  logic [1:0]      lane_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  logic [RegBus-1:0] load_data, aligned;

  assign op_in = mem_op_e'(mem_op);

  load_align u_load_align (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (bus_rdata),
    .data  (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state     <= ST_IDLE;
      op_q      <= OP_NONE;
      lane_q    <= 2'd0;
      err_q     <= 1'b0;
      cnt       <= '0;
      load_data <= ZeroWord;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_sel   <= 4'h0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_mem_op(mem_op)) begin
            op_q      <= op_in;
            lane_q    <= mem_addr[1:0];
            err_q     <= 1'b0;
            cnt       <= '0;
            load_data <= ZeroWord;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            case (op_in)
              OP_SW:   begin bus_sel <= 4'b1111;                bus_wdata <= mem_sdata; end
              OP_SB:   begin bus_sel <= lane_sel(mem_addr[1:0]); bus_wdata <= {4{mem_sdata[7:0]}}; end
              OP_LW:   begin bus_sel <= 4'b1111;                bus_wdata <= 32'h0; end
              default: begin bus_sel <= lane_sel(mem_addr[1:0]); bus_wdata <= 32'h0; end
            endcase
`ifdef MEM_ALIGN_CHECK_EN
            if ((op_in == OP_LW || op_in == OP_SW) && mem_addr[1:0] != 2'b00) begin
              state   <= ST_DONE;
              err_q   <= 1'b1;
              bus_err <= 1'b1;
            end else
`endif
            begin
              state   <= ST_BUSY;
              bus_req <= 1'b1;
              bus_we  <= is_store(op_in);
            end
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            load_data <= aligned;
            state     <= ST_DONE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Watchdog expiry: abandon the access and suppress writeback.
            err_q   <= 1'b1;
            bus_err <= 1'b1;
            state   <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback path is a bubble while stalled; non-memory ops bypass with zero latency.
  always_comb begin
    wb_wdata  = ZeroWord;
    wb_waddr  = NOPRegAddr;
    wb_wr_en  = WriteDisable;
    stall_req = 1'b0;
    if (rst != RstEnable) begin
      case (state)
        ST_IDLE: begin
          if (is_mem_op(mem_op)) begin
            stall_req = 1'b1;
          end else begin
            wb_wdata = wdata;
            wb_waddr = waddr;
            wb_wr_en = wr_en;
          end
        end
        ST_BUSY: stall_req = 1'b1;
        ST_DONE: begin
          wb_wdata = is_load(op_q) ? load_data : wdata;
          wb_waddr = waddr;
          wb_wr_en = wr_en & ~err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT = 4); checks bypass, loads, stores,
// watchdog abort, mid-access reset and the MEM_ALIGN_CHECK_EN behaviour.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        wr_en;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr, mem_sdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] wb_wdata;
  logic [4:0]  wb_waddr;
  logic        wb_wr_en, stall_req, bus_err;

  int checks = 0;
  int failures = 0;

  // Results captured by run_access
  logic [3:0]  r_sel;
  logic        r_we, r_err, r_wen, r_done;
  logic [31:0] r_addr, r_wdata, r_wb;
  int          r_req, r_stall;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wdata     (wdata),
    .waddr     (waddr),
    .wr_en     (wr_en),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_sel   (bus_sel),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .wb_wdata  (wb_wdata),
    .wb_waddr  (wb_waddr),
    .wb_wr_en  (wb_wr_en),
    .stall_req (stall_req),
    .bus_err   (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one access at a negedge and follows it to DONE. ack_at = n pulses
  // bus_ack during the n-th bus_req cycle; 0 means never acknowledge.
  task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] sdata, input int ack_at,
                            input logic [31:0] rdata);
    r_sel = 4'h0; r_we = 1'b0; r_addr = 32'h0; r_wdata = 32'h0;
    r_err = 1'b0; r_wen = 1'b0; r_wb = 32'h0; r_done = 1'b0;
    r_req = 0; r_stall = 0;
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_sdata = sdata; bus_rdata = rdata;
    #1;
    for (int i = 0; i < 40 && !r_done; i++) begin
      if (stall_req) r_stall++;
      if (bus_req) begin
        r_req++;
        if (r_req == 1) begin
          r_sel = bus_sel; r_we = bus_we; r_addr = bus_addr; r_wdata = bus_wdata;
        end
        if (r_req == ack_at) bus_ack = 1'b1;
      end else if (!stall_req) begin
        r_done = 1'b1;
        r_wb = wb_wdata; r_wen = wb_wr_en; r_err = bus_err;
        mem_op = 3'd0;
      end
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
    end
    if (!r_done) begin
      chk("access_timeout", 32'(r_done), 32'd1);
      mem_op = 3'd0;
    end
  endtask

  initial begin
    rst = 1'b1; wdata = 32'hDEAD_BEEF; waddr = 5'd7; wr_en = 1'b1;
    mem_op = 3'd0; mem_addr = 32'h0; mem_sdata = 32'h0;
    bus_rdata = 32'h0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wb_wdata", wb_wdata, 32'h0);
    chk("rst_wb_waddr", 32'(wb_waddr), 32'h0);
    chk("rst_wb_wr_en", 32'(wb_wr_en), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_bus", {bus_req, bus_we, bus_err, bus_sel}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);

    // Bypass for mem_op NONE
    @(negedge clk);
    rst = 1'b0; wdata = 32'h1234_5678; waddr = 5'd5; wr_en = 1'b1;
    #1;
    chk("none_wb_wdata", wb_wdata, 32'h1234_5678);
    chk("none_wb_waddr", 32'(wb_waddr), 32'd5);
    chk("none_wb_wr_en", 32'(wb_wr_en), 32'd1);
    chk("none_stall", 32'(stall_req), 32'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        seen |= bus_req;
        @(negedge clk); #1;
      end
      chk("none_no_req", 32'(seen), 32'd0);
    end
    // Reserved encoding 7 behaves as NONE
    mem_op = 3'd7; wdata = 32'hA5A5_0001; #1;
    chk("op7_stall", 32'(stall_req), 32'd0);
    chk("op7_wb_wdata", wb_wdata, 32'hA5A5_0001);
    mem_op = 3'd0;

    // LB lane 3, ack on 4th BUSY cycle
    wdata = 32'h55; waddr = 5'd3; wr_en = 1'b1;
    run_access(3'd2, 32'h0000_0103, 32'h0, 4, 32'h0000_00F0);
    chk("lb_sel", 32'(r_sel), 32'b0001);
    chk("lb_we", 32'(r_we), 32'd0);
    chk("lb_addr", r_addr, 32'h100);
    chk("lb_wb", r_wb, 32'hFFFF_FFF0);
    chk("lb_wen", 32'(r_wen), 32'd1);
    chk("lb_stall", 32'(r_stall), 32'd5);
    chk("lb_err", 32'(r_err), 32'd0);

    // LB lane 0, positive byte
    run_access(3'd2, 32'h0000_0200, 32'h0, 1, 32'h7F11_2233);
    chk("lb0_sel", 32'(r_sel), 32'b1000);
    chk("lb0_wb", r_wb, 32'h0000_007F);

    // LBU lane 2
    run_access(3'd3, 32'h0000_0102, 32'h0, 1, 32'h1122_F044);
    chk("lbu_sel", 32'(r_sel), 32'b0010);
    chk("lbu_wb", r_wb, 32'h0000_00F0);

    // LW, ack on 2nd BUSY cycle
    run_access(3'd1, 32'h0000_0200, 32'h0, 2, 32'h89AB_CDEF);
    chk("lw_sel", 32'(r_sel), 32'b1111);
    chk("lw_wb", r_wb, 32'h89AB_CDEF);
    chk("lw_stall", 32'(r_stall), 32'd3);

    // SB lane 1
    wdata = 32'h77; wr_en = 1'b0;
    run_access(3'd5, 32'h0000_0101, 32'h0000_00AB, 1, 32'h0);
    chk("sb_we", 32'(r_we), 32'd1);
    chk("sb_sel", 32'(r_sel), 32'b0100);
    chk("sb_wdata", r_wdata, 32'hABAB_ABAB);
    chk("sb_addr", r_addr, 32'h100);
    chk("sb_wb", r_wb, 32'h77);
    chk("sb_wen", 32'(r_wen), 32'd0);

    // SW
    run_access(3'd4, 32'h0000_0300, 32'hCAFE_BABE, 1, 32'h0);
    chk("sw_we", 32'(r_we), 32'd1);
    chk("sw_sel", 32'(r_sel), 32'b1111);
    chk("sw_wdata", r_wdata, 32'hCAFE_BABE);

    // LW without ack: watchdog abort after 4 BUSY cycles
    wr_en = 1'b1;
    run_access(3'd1, 32'h0000_0040, 32'h0, 0, 32'h0);
    chk("to_req_cycles", 32'(r_req), 32'd4);
    chk("to_err", 32'(r_err), 32'd1);
    chk("to_wen", 32'(r_wen), 32'd0);
    chk("to_stall", 32'(r_stall), 32'd5);
    wdata = 32'h0BAD_0000;
    #1;
    chk("to_err_pulse", 32'(bus_err), 32'd0);
    chk("to_idle_bypass", wb_wdata, 32'h0BAD_0000);

    // Ack while IDLE is ignored
    @(negedge clk); bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("idle_ack_req", 32'(bus_req), 32'd0);
    chk("idle_ack_stall", 32'(stall_req), 32'd0);
    chk("idle_ack_err", 32'(bus_err), 32'd0);

    // LW at misaligned 0x102
    run_access(3'd1, 32'h0000_0102, 32'h0, 1, 32'h0102_0304);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_req", 32'(r_req), 32'd0);
    chk("mis_err", 32'(r_err), 32'd1);
    chk("mis_wen", 32'(r_wen), 32'd0);
`else
    chk("mis_req", 32'(r_req), 32'd1);
    chk("mis_addr", r_addr, 32'h100);
    chk("mis_sel", 32'(r_sel), 32'b1111);
    chk("mis_wb", r_wb, 32'h0102_0304);
    chk("mis_wen", 32'(r_wen), 32'd1);
`endif

    // Reset during BUSY, then a late ack
    @(negedge clk);
    mem_op = 3'd1; mem_addr = 32'h0000_0400;
    @(negedge clk); @(negedge clk); #1;
    chk("mid_busy_req", 32'(bus_req), 32'd1);
    rst = 1'b1; #1;
    chk("mid_rst_stall", 32'(stall_req), 32'd0);
    chk("mid_rst_wen", 32'(wb_wr_en), 32'd0);
    @(negedge clk); #1;
    chk("mid_rst_req", 32'(bus_req), 32'd0);
    chk("mid_rst_sel", 32'(bus_sel), 32'd0);
    rst = 1'b0; mem_op = 3'd0; bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("late_ack_req", 32'(bus_req), 32'd0);
    chk("late_ack_stall", 32'(stall_req), 32'd0);
    chk("late_ack_err", 32'(bus_err), 32'd0);
    chk("late_ack_bypass", wb_wdata, 32'h0BAD_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
